ongoru_birimi: RTL and testbench

ONGORU_BIRIMI -- requirements
Module: ongoru_birimi

---
 rtl/ongoru_birimi_if.sv | 25 ++
 rtl/ongoru_birimi.sv | 72 +++++++
 tb/tb_ongoru_birimi.sv | 107 ++++++++++
 3 files changed

// File: rtl/ongoru_birimi_if.sv
// ongoru_birimi_if: fetch-side prediction request/response and execute-side update bus
// master: drives requests and updates, receives predictions and the mispredict count
// slave : the predictor
interface ongoru_birimi_if;
  logic        req_valid_i;
  logic [31:0] req_pc_i;
  logic [31:0] req_inst_i;
  logic        pred_valid_o;
  logic        pred_taken_o;
  logic [31:0] pred_target_o;
  logic        upd_valid_i;
  logic [31:0] upd_pc_i;
  logic [31:0] upd_inst_i;
  logic        upd_taken_i;
  logic [31:0] upd_target_i;
  logic [31:0] mispred_cnt_o;
  modport master (
    output req_valid_i, req_pc_i, req_inst_i, upd_valid_i, upd_pc_i, upd_inst_i, upd_taken_i, upd_target_i,
    input  pred_valid_o, pred_taken_o, pred_target_o, mispred_cnt_o
  );
  modport slave (
    input  req_valid_i, req_pc_i, req_inst_i, upd_valid_i, upd_pc_i, upd_inst_i, upd_taken_i, upd_target_i,
    output pred_valid_o, pred_taken_o, pred_target_o, mispred_cnt_o
  );
endinterface

// File: rtl/ongoru_birimi.sv
// ongoru_birimi: branch predictor with 2-bit counter table and direct-mapped JALR target buffer
// clk_i/rst_i: clock and asynchronous active-high reset
// bus (slave): request -> registered prediction, resolved-branch update, mispredict counter
module ongoru_birimi #(
  parameter int BHT_IDX_W = 6,
  parameter int BTB_IDX_W = 4
) (
  input logic clk_i,
  input logic rst_i,
  ongoru_birimi_if.slave bus
);
  localparam int TAG_W = 30 - BTB_IDX_W;
  localparam logic [6:0] OP_BR = 7'b1100011, OP_JAL = 7'b1101111, OP_JALR = 7'b1100111;
  logic [1:0]       bht     [2**BHT_IDX_W];
  logic             btb_v   [2**BTB_IDX_W];
  logic [TAG_W-1:0] btb_tag [2**BTB_IDX_W];
  logic [31:0]      btb_tgt [2**BTB_IDX_W];
  logic [BHT_IDX_W-1:0] r_bi, u_bi;
  logic [BTB_IDX_W-1:0] r_ti, u_ti;
  logic r_hit, u_hit, mispred;
  logic [32:0] r_pred, u_pred;
  logic [1:0] u_ctr;
  // {taken, target} from the current (pre-update) table contents
  function automatic logic [32:0] predict(input logic [31:0] pc, input logic [31:0] inst,
                                          input logic ctr_msb, input logic hit, input logic [31:0] btb_t);
    logic [31:0] b_imm, j_imm, seq;
    b_imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    j_imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
    seq = pc + 32'd4;
    return inst[6:0] == OP_BR   ? (ctr_msb ? {1'b1, pc + b_imm} : {1'b0, seq}) :
           inst[6:0] == OP_JAL  ? {1'b1, pc + j_imm} :
           inst[6:0] == OP_JALR && hit ? {1'b1, btb_t} : {1'b0, seq};
  endfunction
  assign r_bi = bus.req_pc_i[BHT_IDX_W+1:2];
  assign u_bi = bus.upd_pc_i[BHT_IDX_W+1:2];
  assign r_ti = bus.req_pc_i[BTB_IDX_W+1:2];
  assign u_ti = bus.upd_pc_i[BTB_IDX_W+1:2];
  assign r_hit = btb_v[r_ti] && btb_tag[r_ti] == bus.req_pc_i[31:BTB_IDX_W+2];
  assign u_hit = btb_v[u_ti] && btb_tag[u_ti] == bus.upd_pc_i[31:BTB_IDX_W+2];
  assign r_pred = predict(bus.req_pc_i, bus.req_inst_i, bht[r_bi][1], r_hit, btb_tgt[r_ti]);
  assign u_pred = predict(bus.upd_pc_i, bus.upd_inst_i, bht[u_bi][1], u_hit, btb_tgt[u_ti]);
  assign u_ctr = bht[u_bi];
  assign mispred = u_pred[32] != bus.upd_taken_i || (bus.upd_taken_i && u_pred[31:0] != bus.upd_target_i);
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      for (int i = 0; i < 2**BHT_IDX_W; i++) bht[i] <= 2'b01;
      for (int i = 0; i < 2**BTB_IDX_W; i++) btb_v[i] <= 1'b0;
    end else if (bus.upd_valid_i) begin
      if (bus.upd_inst_i[6:0] == OP_BR)
        bht[u_bi] <= bus.upd_taken_i ? (u_ctr == 2'b11 ? u_ctr : u_ctr + 2'b01)
                                     : (u_ctr == 2'b00 ? u_ctr : u_ctr - 2'b01);
      if (bus.upd_inst_i[6:0] == OP_JALR && bus.upd_taken_i) btb_v[u_ti] <= 1'b1;
    end
  // tag/target are qualified by btb_v, so they need no reset
  always_ff @(posedge clk_i)
    if (!rst_i && bus.upd_valid_i && bus.upd_inst_i[6:0] == OP_JALR && bus.upd_taken_i) begin
      btb_tag[u_ti] <= bus.upd_pc_i[31:BTB_IDX_W+2];
      btb_tgt[u_ti] <= bus.upd_target_i;
    end
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      bus.pred_valid_o  <= 1'b0;
      bus.pred_taken_o  <= 1'b0;
      bus.pred_target_o <= '0;
      bus.mispred_cnt_o <= '0;
    end else begin
      bus.pred_valid_o  <= bus.req_valid_i;
      bus.pred_taken_o  <= bus.req_valid_i & r_pred[32];
      bus.pred_target_o <= bus.req_valid_i ? r_pred[31:0] : '0;
      bus.mispred_cnt_o <= bus.mispred_cnt_o + {31'd0, bus.upd_valid_i && mispred};
    end
endmodule

// File: tb/tb_ongoru_birimi.sv
// tb_ongoru_birimi: directed self-checking bench for ongoru_birimi
module tb_ongoru_birimi;
  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  int checks = 0;
  int errors = 0;
  localparam logic [31:0] BEQ = 32'h0000_0863, JALR = 32'h0000_8067, JAL = 32'h0080_006F, NOP = 32'h0000_0013;
  ongoru_birimi_if bus();
  ongoru_birimi #(.BHT_IDX_W(6), .BTB_IDX_W(4)) dut (.clk_i(clk_i), .rst_i(rst_i), .bus(bus));
  always #5 clk_i = ~clk_i;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask
  task automatic req(input logic [31:0] pc, input logic [31:0] inst);
    bus.req_valid_i = 1'b1;
    bus.req_pc_i = pc;
    bus.req_inst_i = inst;
  endtask
  task automatic upd(input logic [31:0] pc, input logic [31:0] inst, input logic tk, input logic [31:0] tgt);
    bus.upd_valid_i = 1'b1;
    bus.upd_pc_i = pc;
    bus.upd_inst_i = inst;
    bus.upd_taken_i = tk;
    bus.upd_target_i = tgt;
  endtask
  task automatic idle();
    bus.req_valid_i = 1'b0;
    bus.upd_valid_i = 1'b0;
  endtask
  task automatic pred(input string tag, input logic v, input logic tk, input logic [31:0] tgt);
    chk({tag, "_valid"}, {31'd0, bus.pred_valid_o}, {31'd0, v});
    chk({tag, "_taken"}, {31'd0, bus.pred_taken_o}, {31'd0, tk});
    chk({tag, "_target"}, bus.pred_target_o, tgt);
  endtask
  initial begin
    idle();
    bus.req_pc_i = '0; bus.req_inst_i = '0;
    bus.upd_pc_i = '0; bus.upd_inst_i = '0; bus.upd_taken_i = 1'b0; bus.upd_target_i = '0;
    tick(); tick();
    pred("reset", 1'b0, 1'b0, 32'h0);
    chk("reset_cnt", bus.mispred_cnt_o, 32'd0);
    rst_i = 1'b0;
    tick();
    pred("idle", 1'b0, 1'b0, 32'h0);
    req(32'h100, BEQ); tick(); idle();
    pred("beq_first", 1'b1, 1'b0, 32'h104);
    tick();
    pred("no_req", 1'b0, 1'b0, 32'h0);
    upd(32'h100, BEQ, 1'b1, 32'h110); tick();
    chk("cnt_after_upd1", bus.mispred_cnt_o, 32'd1);
    tick(); idle();
    chk("cnt_after_upd2", bus.mispred_cnt_o, 32'd1);
    req(32'h100, BEQ); tick(); idle();
    pred("beq_trained", 1'b1, 1'b1, 32'h110);
    for (int i = 0; i < 5; i++) begin
      upd(32'h100, BEQ, 1'b0, 32'h104); tick();
    end
    idle();
    chk("cnt_after_nt", bus.mispred_cnt_o, 32'd3);
    req(32'h100, BEQ); tick(); idle();
    pred("beq_sat00", 1'b1, 1'b0, 32'h104);
    req(32'h200, JALR); tick(); idle();
    pred("jalr_miss", 1'b1, 1'b0, 32'h204);
    upd(32'h200, JALR, 1'b1, 32'h8000); tick(); idle();
    chk("cnt_after_jalr", bus.mispred_cnt_o, 32'd4);
    req(32'h200, JALR); tick(); idle();
    pred("jalr_hit", 1'b1, 1'b1, 32'h8000);
    req(32'h240, JALR); tick(); idle();
    pred("jalr_tagmiss", 1'b1, 1'b0, 32'h244);
    req(32'h300, JAL); tick(); idle();
    pred("jal", 1'b1, 1'b1, 32'h308);
    upd(32'h300, JAL, 1'b1, 32'h308); tick(); idle();
    chk("cnt_after_jal", bus.mispred_cnt_o, 32'd4);
    req(32'h100, BEQ); upd(32'h100, BEQ, 1'b1, 32'h110); tick(); idle();
    pred("rbw", 1'b1, 1'b0, 32'h104);
    chk("cnt_after_rbw", bus.mispred_cnt_o, 32'd5);
    req(32'h100, BEQ); tick(); idle();
    pred("beq_after_rbw", 1'b1, 1'b0, 32'h104);
    req(32'h400, NOP); tick(); idle();
    pred("none", 1'b1, 1'b0, 32'h404);
    chk("cnt_pre_rst", bus.mispred_cnt_o, 32'd5);
    #2 rst_i = 1'b1;
    #1;
    pred("async_rst", 1'b0, 1'b0, 32'h0);
    chk("async_rst_cnt", bus.mispred_cnt_o, 32'd0);
    req(32'h300, JAL); upd(32'h100, BEQ, 1'b1, 32'h110); tick();
    pred("req_in_rst", 1'b0, 1'b0, 32'h0);
    chk("upd_in_rst_cnt", bus.mispred_cnt_o, 32'd0);
    idle(); rst_i = 1'b0;
    req(32'h200, JALR); tick(); idle();
    pred("jalr_after_rst", 1'b1, 1'b0, 32'h204);
    upd(32'h100, BEQ, 1'b1, 32'h110); tick(); idle();
    chk("cnt_post_rst", bus.mispred_cnt_o, 32'd1);
    req(32'h100, BEQ); tick(); idle();
    pred("ctr01_after_rst", 1'b1, 1'b1, 32'h110);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
